// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: shared definitions for the instruction sequencer.
//   - state_t: sequencer FSM states (ST_FAULT exists only when the
//     SEQ_WATCHDOG_EN macro is defined)
//   - opcode constants and instruction-word field helpers
//     (opcode [2:0], Rx [5:3], Ry [8:6])
package proc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_I = 3'd1,
    ST_LATCH_I = 3'd2,
    ST_LATCH_D = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_EXEC    = 3'd5,
`ifdef SEQ_WATCHDOG_EN
    ST_HALTED  = 3'd6,
    ST_FAULT   = 3'd7
`else
    ST_HALTED  = 3'd6
`endif
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  function automatic logic [2:0] f_opcode(input logic [8:0] w);
    return w[2:0];
  endfunction

  function automatic logic [2:0] f_rx(input logic [8:0] w);
    return w[5:3];
  endfunction

  function automatic logic [2:0] f_ry(input logic [8:0] w);
    return w[8:6];
  endfunction

  // Any opcode with bit 2 set is treated as halt.
  function automatic logic f_is_halt(input logic [8:0] w);
    return w[2];
  endfunction

endpackage

// File: rtl/proc_sequencer_seq_watchdog.sv
// seq_watchdog: EXEC-cycle counter with expiry compare.
//   Clock  in  : clock, rising edge
//   Resetn in  : async active-low reset
//   clear  in  : restart the count (sequencer is about to enter EXEC)
//   tick   in  : one EXEC cycle elapsed without Done
//   expire out : this tick is the LIMIT-th consecutive one
// Only instantiated when SEQ_WATCHDOG_EN is defined.
module seq_watchdog #(
  parameter int LIMIT = 8
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is flagged on the tick that would bring the count to LIMIT, so the
  // sequencer leaves EXEC right after exactly LIMIT idle cycles.
  assign expire = tick && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (tick && !expire)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: fetches 9-bit instruction words (plus the immediate word
// for mvi) from a synchronous program ROM and hands them to the processor
// over DIN with a one-cycle Run pulse, then waits for Done.
//
// Optional feature macro: SEQ_WATCHDOG_EN (EXEC watchdog, FAULT state,
// Fault port).
//
// Ports:
//   Clock   in              : clock, rising edge
//   Resetn  in              : async active-low reset
//   Start   in              : start execution from IDLE / HALTED
//   Stop    in              : stop at the next instruction boundary
//   MemAddr out [ADDR_W-1:0]: ROM read address (combinational)
//   MemData in  [8:0]       : ROM data, one cycle after MemAddr
//   DIN     out [8:0]       : word presented to the processor
//   Run     out             : registered one-cycle instruction start
//   Done    in              : instruction complete strobe
//   PC      out [ADDR_W-1:0]: current instruction address
//   Busy    out             : not in IDLE or HALTED
//   Halted  out             : halt opcode reached
//   Fault   out             : watchdog expired (SEQ_WATCHDOG_EN only)
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | stopped, waiting for Start
// FETCH_I  | ROM address = PC
// LATCH_I  | capture instruction word, decode, address PC+1 for mvi
// LATCH_D  | capture mvi immediate word
// ISSUE    | Run high, DIN = instruction word
// EXEC     | DIN = immediate (mvi) or instruction, wait for Done
// HALTED   | halt word at PC, waiting for Start / Stop
// FAULT    | watchdog expired, left only by reset
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int WDOG_CYCLES = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [8:0]        MemData,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
`ifdef SEQ_WATCHDOG_EN
  output logic              Fault,
`endif
  output logic              Halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic [8:0]        imm_q, imm_d;
  logic              stop_q, stop_d;
  logic              run_q, run_d;

  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        din;
  logic              busy;
  logic              ir_is_mvi;

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign ir_is_mvi = (f_opcode(ir_q) == OP_MVI);

`ifdef SEQ_WATCHDOG_EN
  logic wd_clear, wd_tick, wd_expire;

  // EXEC is only ever entered from ISSUE.
  assign wd_clear = (state_q == ST_ISSUE);
  assign wd_tick  = (state_q == ST_EXEC) && !Done;

  seq_watchdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_seq_watchdog (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clear  (wd_clear),
    .tick   (wd_tick),
    .expire (wd_expire)
  );
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES > 0);
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    stop_d   = stop_q;
    mem_addr = '0;
    din      = '0;

    if (busy && Stop)
      stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (Start && !Stop)
          state_d = ST_FETCH_I;
      end

      ST_FETCH_I: begin
        mem_addr = pc_q;
        state_d  = ST_LATCH_I;
      end

      ST_LATCH_I: begin
        ir_d = MemData;
        if (f_is_halt(MemData)) begin
          state_d = ST_HALTED;
        end else if (f_opcode(MemData) == OP_MVI) begin
          mem_addr = pc_q + PC_ONE;
          state_d  = ST_LATCH_D;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_LATCH_D: begin
        imm_d   = MemData;
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        din     = ir_q;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        din = ir_is_mvi ? imm_q : ir_q;
        if (Done) begin
          pc_d = pc_q + (ir_is_mvi ? PC_TWO : PC_ONE);
          // A Stop arriving together with Done still ends at this boundary.
          state_d = (stop_q || Stop) ? ST_IDLE : ST_FETCH_I;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_expire) begin
          state_d = ST_FAULT;
        end
`endif
      end

      ST_HALTED: begin
        if (Stop) begin
          state_d = ST_IDLE;
        end else if (Start) begin
          pc_d    = '0;
          state_d = ST_FETCH_I;
        end
      end

`ifdef SEQ_WATCHDOG_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE)
      stop_d = 1'b0;

    run_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      stop_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      stop_q  <= stop_d;
      run_q   <= run_d;
    end
  end

  assign MemAddr = mem_addr;
  assign DIN     = din;
  assign Run     = run_q;
  assign PC      = pc_q;
  assign Busy    = busy;
  assign Halted  = (state_q == ST_HALTED);
`ifdef SEQ_WATCHDOG_EN
  assign Fault   = (state_q == ST_FAULT);
`endif

endmodule
